// File: rtl/tdc_hit_fifo_slave.sv
// TDC hit FIFO with local-bus register slave (DATA/STATUS/CONTROL/AF_THRESH).
// Define TDC_FIFO_DROPCNT_EN to add the saturating drop counter at offset 0x10.
module tdc_hit_fifo_slave #(
    parameter logic [15:0] BASE_ADDR  = 16'h0100,
    parameter int unsigned DEPTH_LOG2 = 9,
    parameter int unsigned AF_DEFAULT = 448
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [31:0] hit_data,
    input  logic        hit_valid,
    output logic        hit_ready,
    input  logic        writesignal,
    input  logic        readsignal,
    input  logic [15:0] addressbus,
    inout  wire  [31:0] databus,
    output logic        almost_full,
    output logic        fifo_empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    typedef enum logic [2:0] {
        REG_DATA    = 3'd0,
        REG_STATUS  = 3'd1,
        REG_CONTROL = 3'd2,
        REG_AF      = 3'd3,
        REG_DROP    = 3'd4
    } reg_sel_e;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  rst_done;
    logic                  drive_q;
    logic                  drive_en;
    logic [15:0]           af_thresh;
    logic [31:0]           rd_data;
    logic [31:0]           rd_mux;
    logic [31:0]           drop_cnt;
    reg_sel_e              sel;
    logic                  full;
    logic                  addr_hit;
    logic                  bus_rd;
    logic                  bus_wr;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  flush;
    logic                  clr_ovf;
    logic                  unused_bits;

    assign full        = (count == CW'(DEPTH));
    assign fifo_empty  = (count == '0);
    assign hit_ready   = rst_done && !full;
    assign almost_full = (16'(count) >= af_thresh);

    assign addr_hit = (addressbus[15:5] == BASE_ADDR[15:5]);
    assign sel      = reg_sel_e'(addressbus[4:2]);
    assign bus_rd   = readsignal && addr_hit;
    assign bus_wr   = writesignal && addr_hit;
    assign flush    = bus_wr && (sel == REG_CONTROL) && databus[0];
    assign clr_ovf  = bus_wr && (sel == REG_CONTROL) && databus[1];
    assign push     = hit_valid && hit_ready && !flush;
    assign drop     = hit_valid && full && !flush;
    assign pop      = bus_rd && (sel == REG_DATA) && !fifo_empty;

    assign unused_bits = ^{addressbus[1:0], databus[31:16], databus[15:2]};

    // Written as an if so an x/z address falls through to "not driving".
    always_comb begin
        drive_en = 1'b0;
        if (drive_q && addr_hit && !readsignal && !writesignal)
            drive_en = 1'b1;
    end

    assign databus = drive_en ? rd_data : 'z;

    always_comb begin
        rd_mux = '0;
        case (sel)
            REG_DATA:   rd_mux = fifo_empty ? '0 : mem[rd_ptr];
            REG_STATUS: rd_mux = {12'h000, overflow, almost_full, full,
                                  fifo_empty, 16'(count)};
            REG_AF:     rd_mux = {16'h0000, af_thresh};
            REG_DROP:   rd_mux = drop_cnt;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (push)
            mem[wr_ptr] <= hit_data;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            af_thresh <= 16'(AF_DEFAULT);
            rst_done  <= 1'b0;
            drive_q   <= 1'b0;
            rd_data   <= '0;
        end else begin
            rst_done <= 1'b1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
            if (clr_ovf)
                overflow <= 1'b0;
            else if (drop)
                overflow <= 1'b1;
            if (bus_wr && (sel == REG_AF))
                af_thresh <= databus[15:0];
            if (bus_rd)
                rd_data <= rd_mux;
            // Hold the data phase only while the address keeps decoding to us.
            if (bus_rd)
                drive_q <= 1'b1;
            else
                drive_q <= drive_en;
        end
    end

`ifdef TDC_FIFO_DROPCNT_EN
    always_ff @(posedge sys_clk) begin
        if (sys_rst || flush || clr_ovf)
            drop_cnt <= '0;
        else if (drop && (drop_cnt != '1))
            drop_cnt <= drop_cnt + 1'b1;
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_tdc_hit_fifo_slave.sv
// Directed bench for tdc_hit_fifo_slave (4-word FIFO); bus idle reads all-ones via tri1.
module tb_tdc_hit_fifo_slave;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [31:0] hit_data = '0;
    logic        hit_valid = 1'b0;
    logic        hit_ready;
    logic        writesignal = 1'b0;
    logic        readsignal = 1'b0;
    logic [15:0] addr_val = '0;
    logic        addr_en = 1'b0;
    tri   [15:0] addressbus;
    tri1  [31:0] databus;
    logic [31:0] wdata = '0;
    logic        wdrive = 1'b0;
    logic        almost_full;
    logic        fifo_empty;
    logic [31:0] rd;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] BUS_IDLE = 32'hFFFF_FFFF;
`ifdef TDC_FIFO_DROPCNT_EN
    localparam logic [31:0] DROP_UNIT = 32'd1;
`else
    localparam logic [31:0] DROP_UNIT = 32'd0;
`endif

    assign addressbus = addr_en ? addr_val : 'z;
    assign databus    = wdrive ? wdata : 'z;

    always #5 sys_clk = ~sys_clk;

    tdc_hit_fifo_slave #(
        .BASE_ADDR (16'h0100),
        .DEPTH_LOG2(2),
        .AF_DEFAULT(448)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .hit_data   (hit_data),
        .hit_valid  (hit_valid),
        .hit_ready  (hit_ready),
        .writesignal(writesignal),
        .readsignal (readsignal),
        .addressbus (addressbus),
        .databus    (databus),
        .almost_full(almost_full),
        .fifo_empty (fifo_empty)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        hit_data  = d;
        hit_valid = 1'b1;
        tick();
        hit_valid = 1'b0;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        addr_val    = a;
        addr_en     = 1'b1;
        wdata       = d;
        wdrive      = 1'b1;
        writesignal = 1'b1;
        tick();
        writesignal = 1'b0;
        wdrive      = 1'b0;
        addr_en     = 1'b0;
    endtask

    // Optional hit on the strobe cycle exercises simultaneous push/pop.
    task automatic bus_read(input logic [15:0] a, input logic hv, input logic [31:0] hd,
                            output logic [31:0] d);
        addr_val   = a;
        addr_en    = 1'b1;
        readsignal = 1'b1;
        hit_data   = hd;
        hit_valid  = hv;
        tick();
        readsignal = 1'b0;
        hit_valid  = 1'b0;
        @(negedge sys_clk);
        d = databus;
        addr_en = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        check_val("rst_hit_ready", 32'(hit_ready), 32'd0);
        check_val("rst_empty", 32'(fifo_empty), 32'd1);
        check_val("rst_af", 32'(almost_full), 32'd0);
        check_val("rst_databus", databus, BUS_IDLE);
        sys_rst = 1'b0;
        tick();
        check_val("post_rst_hit_ready", 32'(hit_ready), 32'd1);
        bus_read(16'h010C, 1'b0, '0, rd); check_val("rst_af_thresh", rd, 32'd448);
        bus_read(16'h0104, 1'b0, '0, rd); check_val("rst_status", rd, 32'h0001_0000);
        bus_read(16'h0108, 1'b0, '0, rd); check_val("control_rd0", rd, 32'd0);
        bus_read(16'h0114, 1'b0, '0, rd); check_val("unmapped_rd0", rd, 32'd0);
        bus_read(16'h0110, 1'b0, '0, rd); check_val("rst_dropcnt", rd, 32'd0);

        push(32'hA1); push(32'hA2); push(32'hA3);
        check_val("t1_not_empty", 32'(fifo_empty), 32'd0);
        bus_read(16'h0104, 1'b0, '0, rd); check_val("t1_status", rd, 32'h0000_0003);
        bus_read(16'h0100, 1'b0, '0, rd); check_val("t1_data0", rd, 32'hA1);
        bus_read(16'h0101, 1'b0, '0, rd); check_val("t1_data1", rd, 32'hA2);
        bus_read(16'h0103, 1'b0, '0, rd); check_val("t1_data2", rd, 32'hA3);
        check_val("t1_empty", 32'(fifo_empty), 32'd1);

        for (int i = 0; i < 4; i++) push(32'hB0 + 32'(i));
        check_val("t2_ready_full", 32'(hit_ready), 32'd0);
        push(32'hB4); push(32'hB5);
        bus_read(16'h0104, 1'b0, '0, rd); check_val("t2_status_full", rd, 32'h000A_0004);
        bus_read(16'h0110, 1'b0, '0, rd); check_val("t2_dropcnt", rd, 2 * DROP_UNIT);
        bus_read(16'h0100, 1'b1, 32'hEE, rd); check_val("t2_full_pop", rd, 32'hB0);
        bus_read(16'h0104, 1'b0, '0, rd); check_val("t2_status_pop", rd, 32'h0008_0003);
        bus_read(16'h0110, 1'b0, '0, rd); check_val("t2_dropcnt3", rd, 3 * DROP_UNIT);
        bus_write(16'h0108, 32'd2);
        bus_read(16'h0104, 1'b0, '0, rd); check_val("t2_ovf_clr", rd, 32'h0000_0003);
        bus_read(16'h0110, 1'b0, '0, rd); check_val("t2_drop_clr", rd, 32'd0);
        hit_data  = 32'hF0;
        hit_valid = 1'b1;
        bus_write(16'h0108, 32'd1);
        hit_valid = 1'b0;
        bus_read(16'h0104, 1'b0, '0, rd); check_val("t2_flush_push", rd, 32'h0001_0000);

        bus_read(16'h0100, 1'b1, 32'hC7, rd); check_val("t3_empty_rd", rd, 32'd0);
        bus_read(16'h0104, 1'b0, '0, rd); check_val("t3_status", rd, 32'h0000_0001);
        bus_read(16'h0100, 1'b0, '0, rd); check_val("t3_data", rd, 32'hC7);

        bus_write(16'h010C, 32'd2);
        bus_write(16'h020C, 32'd5);
        bus_write(16'h011C, 32'd7);
        bus_read(16'h010C, 1'b0, '0, rd); check_val("t4_thresh", rd, 32'd2);
        push(32'hD1);
        check_val("t4_af_low", 32'(almost_full), 32'd0);
        push(32'hD2);
        check_val("t4_af_high", 32'(almost_full), 32'd1);
        bus_read(16'h0104, 1'b0, '0, rd); check_val("t4_status", rd, 32'h0004_0002);
        bus_write(16'h0108, 32'd1);
        check_val("t4_flush_af", 32'(almost_full), 32'd0);
        check_val("t4_flush_empty", 32'(fifo_empty), 32'd1);
        bus_read(16'h0104, 1'b0, '0, rd); check_val("t4_flush_status", rd, 32'h0001_0000);

        push(32'hE5);
        addr_val   = 16'h0100;
        addr_en    = 1'b1;
        readsignal = 1'b1;
        @(negedge sys_clk);
        check_val("t5_strobe_z", databus, BUS_IDLE);
        tick();
        readsignal = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            check_val($sformatf("t5_hold%0d", i), databus, 32'hE5);
            tick();
        end
        addr_en = 1'b0;
        @(negedge sys_clk);
        check_val("t5_release_z", databus, BUS_IDLE);
        tick();

        push(32'hE6); push(32'hE7);
        addr_val   = 16'h0100;
        addr_en    = 1'b1;
        readsignal = 1'b1;
        tick();
        readsignal = 1'b0;
        @(negedge sys_clk);
        check_val("t5r_hold", databus, 32'hE6);
        tick();
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check_val("t5r_pre_rst", databus, 32'hE6);
        tick();
        @(negedge sys_clk);
        check_val("t5r_rst_z", databus, BUS_IDLE);
        sys_rst = 1'b0;
        addr_en = 1'b0;
        tick();
        check_val("t5r_hit_ready", 32'(hit_ready), 32'd1);
        bus_read(16'h0104, 1'b0, '0, rd); check_val("t5r_status", rd, 32'h0001_0000);
        bus_read(16'h010C, 1'b0, '0, rd); check_val("t5r_af_thresh", rd, 32'd448);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
